ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_if.sv | 33 +++
 rtl/ps2_key_decoder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_if.sv
// ps2_key_if -- bundles the PS/2 pins, the decoded player controls and the
// receiver status of ps2_key_decoder.
//   master : the decoder (samples the pins, drives controls and status)
//   slave  : the environment (drives the pins, consumes controls and status)
interface ps2_key_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       p1_move_left;
   logic       p1_move_right;
   logic       p1_jump;
   logic       p1_smash;
   logic       p2_move_left;
   logic       p2_move_right;
   logic       p2_jump;
   logic       p2_smash;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;

   modport master (
      input  ps2_clk, ps2_data,
      output p1_move_left, p1_move_right, p1_jump, p1_smash,
      output p2_move_left, p2_move_right, p2_jump, p2_smash,
      output rx_byte, rx_valid, frame_err
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  p1_move_left, p1_move_right, p1_jump, p1_smash,
      input  p2_move_left, p2_move_right, p2_jump, p2_smash,
      input  rx_byte, rx_valid, frame_err
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder -- receive-only PS/2 keyboard front end for the game.
// Conditions the raw ps2_clk/ps2_data pins, assembles 11-bit frames, decodes
// make/break scan codes (with the E0 extended prefix) and holds eight player
// control levels for the physics block.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames whose
// data+parity bits are not odd are dropped as errors; otherwise the parity
// bit is received and ignored.
module ps2_key_decoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int TO_W        = 17
) (
   input  logic      clk,
   input  logic      rst_n,
   ps2_key_if.master bus
);

   localparam int FC_W = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_E0   = 2'd1,
      ST_F0   = 2'd2,
      ST_E0F0 = 2'd3
   } dec_state_e;

   // Key vector layout: [3:0] player 1 left/right/jump/smash,
   //                    [7:4] player 2 left/right/jump/smash.
   localparam logic [2:0] K_P1_LEFT  = 3'd0;
   localparam logic [2:0] K_P1_RIGHT = 3'd1;
   localparam logic [2:0] K_P1_JUMP  = 3'd2;
   localparam logic [2:0] K_P1_SMASH = 3'd3;
   localparam logic [2:0] K_P2_LEFT  = 3'd4;
   localparam logic [2:0] K_P2_RIGHT = 3'd5;
   localparam logic [2:0] K_P2_JUMP  = 3'd6;
   localparam logic [2:0] K_P2_SMASH = 3'd7;

   // Odd parity holds when the XOR over data plus parity bit is 1.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

   // Maps a scan code in the base or extended namespace to {hit, key index}.
   function automatic logic [3:0] map_code(input logic ext, input logic [7:0] code);
      logic [3:0] r;
      r = 4'd0;
      if (ext) begin
         case (code)
            8'h6B:   r = {1'b1, K_P2_LEFT};
            8'h74:   r = {1'b1, K_P2_RIGHT};
            8'h75:   r = {1'b1, K_P2_JUMP};
            8'h72:   r = {1'b1, K_P2_SMASH};
            default: r = 4'd0;
         endcase
      end else begin
         case (code)
            8'h1C:   r = {1'b1, K_P1_LEFT};
            8'h23:   r = {1'b1, K_P1_RIGHT};
            8'h1D:   r = {1'b1, K_P1_JUMP};
            8'h1B:   r = {1'b1, K_P1_SMASH};
            default: r = 4'd0;
         endcase
      end
      return r;
   endfunction

   // Keyboard status/ack bytes that carry no key meaning between codes.
   function automatic logic is_filler(input logic [7:0] code);
      logic r;
      case (code)
         8'hAA, 8'hFA, 8'hEE, 8'h00: r = 1'b1;
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

   // ---------------- state ----------------
   logic             clk_meta_q, clk_sync_q;
   logic             data_meta_q, data_sync_q;
   logic             filt_q, filt_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic             fall_s;

   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [8:0]       shift_q, shift_d;
   logic             start_bad_q, start_bad_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             parity_ok_s;
   logic             good_s;

   dec_state_e       state_q, state_d;
   logic [7:0]       keys_q, keys_d;
   logic             ext_s;
   logic [3:0]       slot_s;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok_s = odd_parity_ok(shift_q);
`else
   assign parity_ok_s = 1'b1;
`endif

   // Two-flop synchronisers for both raw pins; idle bus level is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= bus.ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= bus.ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   // Glitch filter: the accepted clock level flips only after FILTER_LEN
   // consecutive synchronised samples disagree with it.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      if (clk_sync_q != filt_q) begin
         if (fcnt_q == FC_W'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q;
            fcnt_d = '0;
         end else begin
            fcnt_d = fcnt_q + FC_W'(1);
         end
      end else begin
         fcnt_d = '0;
      end
      fall_s = filt_q & ~filt_d;
   end

   // Frame receiver: start, 8 data LSB first, parity, stop; plus the
   // mid-frame inactivity timeout.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      start_bad_d = start_bad_q;
      to_cnt_d    = to_cnt_q;
      rx_byte_d   = rx_byte_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      good_s      = 1'b0;
      if (fall_s) begin
         to_cnt_d = '0;
         case (bit_cnt_q)
            4'd0: begin
               start_bad_d = data_sync_q;
               bit_cnt_d   = 4'd1;
            end
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
               shift_d   = {data_sync_q, shift_q[8:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            4'd10: begin
               good_s    = ~start_bad_q & data_sync_q & parity_ok_s;
               bit_cnt_d = 4'd0;
               if (good_s) begin
                  rx_byte_d  = shift_q[7:0];
                  rx_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: begin
               // Unreachable count: drop whatever was in flight.
               bit_cnt_d   = 4'd0;
               frame_err_d = 1'b1;
            end
         endcase
      end else if (bit_cnt_q != 4'd0) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            bit_cnt_d   = 4'd0;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   // Scan-code decoder: tracks E0/F0 prefixes and sets/clears key levels.
   always_comb begin
      state_d = state_q;
      keys_d  = keys_q;
      ext_s   = (state_q == ST_E0) || (state_q == ST_E0F0);
      slot_s  = map_code(ext_s, rx_byte_q);
      if (rx_valid_q) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte_q == 8'hE0) begin
                  state_d = ST_E0;
               end else if (rx_byte_q == 8'hF0) begin
                  state_d = ST_F0;
               end else if (is_filler(rx_byte_q)) begin
                  state_d = ST_IDLE;
               end else if (slot_s[3]) begin
                  keys_d[slot_s[2:0]] = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_E0: begin
               if (rx_byte_q == 8'hF0) begin
                  state_d = ST_E0F0;
               end else begin
                  state_d = ST_IDLE;
                  if (slot_s[3]) begin
                     keys_d[slot_s[2:0]] = 1'b1;
                  end else begin
                     keys_d = keys_q;
                  end
               end
            end
            ST_F0, ST_E0F0: begin
               state_d = ST_IDLE;
               if (slot_s[3]) begin
                  keys_d[slot_s[2:0]] = 1'b0;
               end else begin
                  keys_d = keys_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers for filter, receiver, decoder and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q      <= 1'b1;
         fcnt_q      <= '0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 9'd0;
         start_bad_q <= 1'b0;
         to_cnt_q    <= '0;
         rx_byte_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         state_q     <= ST_IDLE;
         keys_q      <= 8'd0;
      end else begin
         filt_q      <= filt_d;
         fcnt_q      <= fcnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         start_bad_q <= start_bad_d;
         to_cnt_q    <= to_cnt_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         state_q     <= state_d;
         keys_q      <= keys_d;
      end
   end

   assign bus.p1_move_left  = keys_q[K_P1_LEFT];
   assign bus.p1_move_right = keys_q[K_P1_RIGHT];
   assign bus.p1_jump       = keys_q[K_P1_JUMP];
   assign bus.p1_smash      = keys_q[K_P1_SMASH];
   assign bus.p2_move_left  = keys_q[K_P2_LEFT];
   assign bus.p2_move_right = keys_q[K_P2_RIGHT];
   assign bus.p2_jump       = keys_q[K_P2_JUMP];
   assign bus.p2_smash      = keys_q[K_P2_SMASH];
   assign bus.rx_byte       = rx_byte_q;
   assign bus.rx_valid      = rx_valid_q;
   assign bus.frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder -- drives PS/2 frames (directed and random) into
// ps2_key_decoder and compares against a scan-code reference model.
module tb_ps2_key_decoder;
   localparam int TO_CYC = 3000;
   localparam int HP     = 20;   // PS/2 half period in clk cycles

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ps2_key_if bus ();

   ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC), .TO_W(17)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] base_codes [4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};
   logic [7:0] ext_codes  [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
   logic [7:0] m_keys = 8'h00;
   bit         m_ext  = 1'b0;
   bit         m_brk  = 1'b0;
   logic [7:0] exp_q [$];
   int         rxv_cnt = 0, ferr_cnt = 0;
   int         exp_rxv = 0, exp_ferr = 0;

   function automatic int key_idx(input bit ext, input logic [7:0] c);
      for (int i = 0; i < 4; i++) begin
         if (!ext && base_codes[i] == c) return i;
         if (ext && ext_codes[i] == c) return i + 4;
      end
      return -1;
   endfunction

   task automatic model_apply(input logic [7:0] b);
      int k;
      if (!m_ext && !m_brk) begin
         if (b == 8'hE0) m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'h00})) begin
            k = key_idx(1'b0, b);
            if (k >= 0) m_keys[k] = 1'b1;
         end
      end else if (!m_brk) begin
         if (b == 8'hF0) m_brk = 1'b1;
         else begin
            k = key_idx(1'b1, b);
            if (k >= 0) m_keys[k] = 1'b1;
            m_ext = 1'b0;
         end
      end else begin
         k = key_idx(m_ext, b);
         if (k >= 0) m_keys[k] = 1'b0;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   function automatic logic [7:0] obs_keys();
      return {bus.p2_smash, bus.p2_jump, bus.p2_move_right, bus.p2_move_left,
              bus.p1_smash, bus.p1_jump, bus.p1_move_right, bus.p1_move_left};
   endfunction

   // Monitor: keys must hold old value at rx_valid and show the update one cycle later.
   bit         pend     = 1'b0;
   logic       prev_rxv = 1'b0;
   logic [7:0] eb;
   always @(negedge clk) begin
      if (!rst_n) begin
         pend     = 1'b0;
         prev_rxv = 1'b0;
         m_keys   = 8'h00;
         m_ext    = 1'b0;
         m_brk    = 1'b0;
         exp_q.delete();
      end else begin
         if (pend) begin
            check_eq("keys_t2", obs_keys(), m_keys);
            pend = 1'b0;
         end
         if (bus.rx_valid) begin
            rxv_cnt++;
            check_eq("rxv_pulse", prev_rxv, 1'b0);
            check_eq("rx_expected", exp_q.size() != 0, 1'b1);
            check_eq("keys_t1", obs_keys(), m_keys);
            if (exp_q.size() != 0) begin
               eb = exp_q.pop_front();
               check_eq("rx_byte", bus.rx_byte, eb);
               model_apply(eb);
            end
            pend = 1'b1;
         end
         if (bus.frame_err) ferr_cnt++;
         prev_rxv = bus.rx_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit flip_par,
                             input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         wait_clks(HP);
         bus.ps2_clk = 1'b0;
         wait_clks(HP);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
      wait_clks(HP);
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_rxv"}, rxv_cnt, exp_rxv);
      check_eq({tag, "_ferr"}, ferr_cnt, exp_ferr);
      check_eq({tag, "_keys"}, obs_keys(), m_keys);
   endtask

   task automatic good_frame(input logic [7:0] b, input bit flip_par);
      exp_q.push_back(b);
      exp_rxv++;
      send_frame(b, 1'b0, flip_par, 11);
      wait_clks(5);
      check_counts("good");
   endtask

   task automatic bad_frame(input logic [7:0] b, input bit bad_stop, input bit flip_par);
      exp_ferr++;
      send_frame(b, bad_stop, flip_par, 11);
      wait_clks(5);
      check_counts("bad");
   endtask

   function automatic logic [7:0] rand_code();
      logic [7:0] r;
      case ($urandom_range(0, 9))
         0, 1:    r = 8'hE0;
         2, 3:    r = 8'hF0;
         4, 5:    r = base_codes[$urandom_range(0, 3)];
         6, 7:    r = ext_codes[$urandom_range(0, 3)];
         8: begin
            case ($urandom_range(0, 5))
               0:       r = 8'hAA;
               1:       r = 8'hFA;
               2:       r = 8'hEE;
               3:       r = 8'h00;
               4:       r = 8'hE1;
               default: r = 8'h75;
            endcase
         end
         default: r = 8'($urandom_range(0, 255));
      endcase
      return r;
   endfunction

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      #2 rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("rst_keys", obs_keys(), 8'h00);
      check_eq("rst_rx_byte", bus.rx_byte, 8'h00);
      check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
      check_eq("rst_frame_err", bus.frame_err, 1'b0);
      rst_n = 1'b1;
      wait_clks(10);

      // W make then break
      good_frame(8'h1D, 1'b0);
      check_eq("w_make_jump", bus.p1_jump, 1'b1);
      check_eq("w_rx_byte", bus.rx_byte, 8'h1D);
      good_frame(8'hF0, 1'b0);
      good_frame(8'h1D, 1'b0);
      check_eq("w_break_jump", bus.p1_jump, 1'b0);

      // extended arrows, base keypad 4 must not touch p2
      good_frame(8'hE0, 1'b0); good_frame(8'h6B, 1'b0);
      good_frame(8'hE0, 1'b0); good_frame(8'h74, 1'b0);
      good_frame(8'hE0, 1'b0); good_frame(8'hF0, 1'b0); good_frame(8'h6B, 1'b0);
      check_eq("p2_left_released", bus.p2_move_left, 1'b0);
      check_eq("p2_right_held", bus.p2_move_right, 1'b1);
      good_frame(8'h6B, 1'b0);
      check_eq("kp4_no_p2_left", bus.p2_move_left, 1'b0);

      // typematic repeat, break, filler byte
      for (int i = 0; i < 4; i++) good_frame(8'h1C, 1'b0);
      check_eq("typematic_left", bus.p1_move_left, 1'b1);
      good_frame(8'hF0, 1'b0); good_frame(8'h1C, 1'b0);
      check_eq("left_released", bus.p1_move_left, 1'b0);
      good_frame(8'hAA, 1'b0);

      // bad stop bit, then recovery
      bad_frame(8'h55, 1'b1, 1'b0);
      good_frame(8'h23, 1'b0);
      check_eq("right_after_err", bus.p1_move_right, 1'b1);

      // mid-frame timeout
      send_frame(8'h3C, 1'b0, 1'b0, 5);
      wait_clks(TO_CYC + 10);
      exp_ferr++;
      check_counts("timeout");
      good_frame(8'h1B, 1'b0);
      check_eq("smash_after_to", bus.p1_smash, 1'b1);

      // random traffic with occasional corrupted frames
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) bad_frame(rand_code(), 1'b1, 1'b0);
         else good_frame(rand_code(), 1'b0);
      end

      // return the decoder to idle and release A
      good_frame(8'h00, 1'b0);
      good_frame(8'hF0, 1'b0); good_frame(8'h1C, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      bad_frame(8'h1C, 1'b0, 1'b1);
      check_eq("par_left_off", bus.p1_move_left, 1'b0);
`else
      good_frame(8'h1C, 1'b1);
      check_eq("par_ignored_left", bus.p1_move_left, 1'b1);
`endif

      // asynchronous reset mid-frame with a key held
      good_frame(8'h1D, 1'b0);
      check_eq("pre_rst_jump", bus.p1_jump, 1'b1);
      send_frame(8'h1D, 1'b0, 1'b0, 4);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("async_rst_keys", obs_keys(), 8'h00);
      check_eq("async_rst_rxv", bus.rx_valid, 1'b0);
      wait_clks(5);
      rst_n = 1'b1;
      wait_clks(5);
      good_frame(8'h1D, 1'b0);
      check_eq("post_rst_jump", bus.p1_jump, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
